// File: rtl/i2c_arbiter.sv
// i2c_arbiter: round-robin arbiter and sequencer that shares a single i2c_master
// between NREQ requesters. It latches the winning request, drives the master
// and follows the busy handshake. It then returns read data and status to the
// winner with a one-cycle done pulse.
// Optional feature macro: I2C_ARB_RETRY_EN (retry NACKed transactions up to MAX_RETRY times).

module i2c_arbiter #(
    parameter int NREQ      = 4,
    parameter int TMO_W     = 8,
    parameter int MAX_RETRY = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [7*NREQ-1:0]   req_addr,
    input  logic [NREQ-1:0]     req_rw,
    input  logic [5*NREQ-1:0]   req_mem_addr,
    input  logic [8*NREQ-1:0]   req_data_wr,
    output logic [NREQ-1:0]     gnt,
    output logic [NREQ-1:0]     done,
    output logic [7:0]          rsp_data,
    output logic                rsp_err,
    output logic                rsp_tmo,
    output logic                arb_busy,
    output logic                m_en,
    output logic [6:0]          m_addr,
    output logic                m_rw,
    output logic [4:0]          m_mem_addr,
    output logic [7:0]          m_data_wr,
    input  logic                m_busy,
    input  logic                m_ack_err,
    input  logic [7:0]          m_data_rd
);

`ifdef I2C_ARB_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    // Without the retry option a NACK always finishes on the first attempt.
    localparam int RETRIES = RETRY_EN ? MAX_RETRY : 0;

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int ATT_W = $clog2(MAX_RETRY + 2);
    localparam logic [TMO_W-1:0] TMO_MAX = '1;
    localparam logic [PTR_W:0]   NREQ_W  = (PTR_W + 1)'(NREQ);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] win_q, win_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREQ-1:0]  done_q, done_d;
    logic             m_en_q, m_en_d;
    logic [6:0]       m_addr_q, m_addr_d;
    logic             m_rw_q, m_rw_d;
    logic [4:0]       m_mem_addr_q, m_mem_addr_d;
    logic [7:0]       m_data_wr_q, m_data_wr_d;
    logic [7:0]       rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;
    logic             rsp_tmo_q, rsp_tmo_d;
    logic             arb_busy_q, arb_busy_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic [ATT_W-1:0] attempt_q, attempt_d;

    logic             win_found;
    logic [PTR_W-1:0] win_idx;
    logic [PTR_W:0]   cand;
    logic [PTR_W-1:0] ptr_next;
    logic [TMO_W-1:0] cnt_inc;
    logic             accept;
    logic             tmo_hit;
    logic             retry_ok;

    assign accept   = win_found && !m_busy;
    assign cnt_inc  = cnt_q + 1'b1;
    assign tmo_hit  = (cnt_inc == TMO_MAX);
    assign retry_ok = m_ack_err && (int'(attempt_q) < RETRIES);
    assign ptr_next = (win_q == LAST_IDX) ? '0 : win_q + 1'b1;

    // Rotating priority search: first set request starting at ptr and wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, ptr_q} + (PTR_W + 1)'(i);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!win_found && req[cand[PTR_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[PTR_W-1:0];
            end
        end
    end

    // State register; reset leaves the arbiter idle even if the master is still busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic for the accept / launch / wait / done sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                if (m_busy) begin
                    state_d = WAIT;
                end else if (tmo_hit) begin
                    state_d = DONE;
                end
            end
            WAIT: begin
                if (!m_busy) begin
                    state_d = retry_ok ? LAUNCH : DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered outputs and datapath: grant, master fields, counters and response.
    always_comb begin
        ptr_d        = ptr_q;
        win_d        = win_q;
        gnt_d        = gnt_q;
        done_d       = '0;
        m_en_d       = m_en_q;
        m_addr_d     = m_addr_q;
        m_rw_d       = m_rw_q;
        m_mem_addr_d = m_mem_addr_q;
        m_data_wr_d  = m_data_wr_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        rsp_tmo_d    = rsp_tmo_q;
        cnt_d        = cnt_q;
        attempt_d    = attempt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    win_d        = win_idx;
                    gnt_d        = NREQ'(1) << win_idx;
                    m_en_d       = 1'b1;
                    m_addr_d     = req_addr[win_idx*7 +: 7];
                    m_rw_d       = req_rw[win_idx];
                    m_mem_addr_d = req_mem_addr[win_idx*5 +: 5];
                    m_data_wr_d  = req_data_wr[win_idx*8 +: 8];
                    cnt_d        = '0;
                    attempt_d    = '0;
                end
            end
            LAUNCH: begin
                if (m_busy) begin
                    m_en_d = 1'b0;
                    cnt_d  = '0;
                end else if (tmo_hit) begin
                    m_en_d    = 1'b0;
                    cnt_d     = '0;
                    rsp_err_d = 1'b1;
                    rsp_tmo_d = 1'b1;
                    done_d    = gnt_q;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            WAIT: begin
                if (!m_busy) begin
                    if (retry_ok) begin
                        attempt_d = attempt_q + 1'b1;
                        m_en_d    = 1'b1;
                        cnt_d     = '0;
                    end else begin
                        rsp_err_d  = m_ack_err;
                        rsp_tmo_d  = 1'b0;
                        rsp_data_d = m_rw_q ? 8'h00 : m_data_rd;
                        done_d     = gnt_q;
                    end
                end
            end
            DONE: begin
                gnt_d = '0;
                ptr_d = ptr_next;
            end
            default: begin
                gnt_d  = '0;
                m_en_d = 1'b0;
            end
        endcase
        arb_busy_d = (state_d != IDLE);
    end

    // Datapath registers; async reset drops grant and enable at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q        <= '0;
            win_q        <= '0;
            gnt_q        <= '0;
            done_q       <= '0;
            m_en_q       <= 1'b0;
            m_addr_q     <= '0;
            m_rw_q       <= 1'b0;
            m_mem_addr_q <= '0;
            m_data_wr_q  <= '0;
            rsp_data_q   <= '0;
            rsp_err_q    <= 1'b0;
            rsp_tmo_q    <= 1'b0;
            arb_busy_q   <= 1'b0;
            cnt_q        <= '0;
            attempt_q    <= '0;
        end else begin
            ptr_q        <= ptr_d;
            win_q        <= win_d;
            gnt_q        <= gnt_d;
            done_q       <= done_d;
            m_en_q       <= m_en_d;
            m_addr_q     <= m_addr_d;
            m_rw_q       <= m_rw_d;
            m_mem_addr_q <= m_mem_addr_d;
            m_data_wr_q  <= m_data_wr_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            rsp_tmo_q    <= rsp_tmo_d;
            arb_busy_q   <= arb_busy_d;
            cnt_q        <= cnt_d;
            attempt_q    <= attempt_d;
        end
    end

    assign gnt        = gnt_q;
    assign done       = done_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_tmo    = rsp_tmo_q;
    assign arb_busy   = arb_busy_q;
    assign m_en       = m_en_q;
    assign m_addr     = m_addr_q;
    assign m_rw       = m_rw_q;
    assign m_mem_addr = m_mem_addr_q;
    assign m_data_wr  = m_data_wr_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// tb_i2c_arbiter: randomized transactions against a transaction-level reference
// model of the arbiter, with a simple i2c_master stand-in driving busy/ack/data.

module tb_i2c_arbiter;

    localparam int NREQ       = 4;
    localparam int TMO_W      = 4;
    localparam int MAX_RETRY  = 2;
    localparam int TMO_CYCLES = (1 << TMO_W) - 1;

`ifdef I2C_ARB_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [7*NREQ-1:0]   req_addr;
    logic [NREQ-1:0]     req_rw;
    logic [5*NREQ-1:0]   req_mem_addr;
    logic [8*NREQ-1:0]   req_data_wr;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     done;
    logic [7:0]          rsp_data;
    logic                rsp_err;
    logic                rsp_tmo;
    logic                arb_busy;
    logic                m_en;
    logic [6:0]          m_addr;
    logic                m_rw;
    logic [4:0]          m_mem_addr;
    logic [7:0]          m_data_wr;
    logic                m_busy;
    logic                m_ack_err;
    logic [7:0]          m_data_rd;

    i2c_arbiter #(
        .NREQ      (NREQ),
        .TMO_W     (TMO_W),
        .MAX_RETRY (MAX_RETRY)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_addr     (req_addr),
        .req_rw       (req_rw),
        .req_mem_addr (req_mem_addr),
        .req_data_wr  (req_data_wr),
        .gnt          (gnt),
        .done         (done),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .rsp_tmo      (rsp_tmo),
        .arb_busy     (arb_busy),
        .m_en         (m_en),
        .m_addr       (m_addr),
        .m_rw         (m_rw),
        .m_mem_addr   (m_mem_addr),
        .m_data_wr    (m_data_wr),
        .m_busy       (m_busy),
        .m_ack_err    (m_ack_err),
        .m_data_rd    (m_data_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: rotating pointer and last reported response.
    int         model_ptr = 0;
    logic [7:0] exp_data  = 8'h00;
    logic       exp_err   = 1'b0;
    logic       exp_tmo   = 1'b0;

    // Per-requester fields and master behaviour for the next transaction.
    logic [6:0] f_addr [NREQ];
    logic       f_rw   [NREQ];
    logic [4:0] f_mem  [NREQ];
    logic [7:0] f_data [NREQ];
    logic       ack_v;
    logic [7:0] data_v;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Winner is the first requesting index found walking upward from the pointer.
    function automatic int pickWinner(input logic [NREQ-1:0] rv);
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (model_ptr + k) % NREQ;
            if (rv[idx]) return idx;
        end
        return 0;
    endfunction

    task automatic randomizeFields();
        for (int i = 0; i < NREQ; i++) begin
            f_addr[i] = 7'($urandom);
            f_rw[i]   = 1'($urandom);
            f_mem[i]  = 5'($urandom);
            f_data[i] = 8'($urandom);
        end
        ack_v  = 1'($urandom);
        data_v = 8'($urandom);
    endtask

    task automatic driveFields();
        for (int i = 0; i < NREQ; i++) begin
            req_addr[7*i +: 7]     = f_addr[i];
            req_rw[i]              = f_rw[i];
            req_mem_addr[5*i +: 5] = f_mem[i];
            req_data_wr[8*i +: 8]  = f_data[i];
        end
    endtask

    task automatic checkFields(input string tag, input int w);
        checkOutput({tag, "_addr"}, 32'(m_addr), 32'(f_addr[w]));
        checkOutput({tag, "_rw"},   32'(m_rw), 32'(f_rw[w]));
        checkOutput({tag, "_mem"},  32'(m_mem_addr), 32'(f_mem[w]));
        checkOutput({tag, "_wdat"}, 32'(m_data_wr), 32'(f_data[w]));
    endtask

    // One full transaction from an idle arbiter, called at a negedge.
    task automatic applyStimulus(input logic [NREQ-1:0] rv, input bit tmo_mode,
                                 input int foreign_k, input bit drop_req);
        int w;
        int n;
        int launches;
        int d;
        int len;
        driveFields();
        req = rv;
        if (foreign_k > 0) begin
            m_busy = 1'b1;
            repeat (foreign_k) begin
                @(negedge clk);
                checkOutput("foreign_m_en", 32'(m_en), 32'd0);
                checkOutput("foreign_gnt", 32'(gnt), 32'd0);
                checkOutput("foreign_arb_busy", 32'(arb_busy), 32'd0);
            end
            m_busy = 1'b0;
        end
        w = pickWinner(rv);
        @(negedge clk);
        checkOutput("launch_m_en", 32'(m_en), 32'd1);
        checkOutput("launch_gnt", 32'(gnt), 32'(1) << w);
        checkOutput("launch_arb_busy", 32'(arb_busy), 32'd1);
        checkOutput("launch_done", 32'(done), 32'd0);
        checkFields("launch", w);
        if (drop_req) req = '0;
        if (tmo_mode) begin
            n = 0;
            while (m_en === 1'b1 && n < 40) begin
                n++;
                @(negedge clk);
            end
            checkOutput("tmo_len", 32'(n), 32'(TMO_CYCLES));
            exp_err = 1'b1;
            exp_tmo = 1'b1;
        end else begin
            launches = (ack_v && RETRY_EN) ? MAX_RETRY + 1 : 1;
            for (int a = 0; a < launches; a++) begin
                if (a > 0) checkOutput("retry_m_en", 32'(m_en), 32'd1);
                d = $urandom_range(0, 3);
                repeat (d) begin
                    @(negedge clk);
                    checkOutput("hold_m_en", 32'(m_en), 32'd1);
                end
                m_busy    = 1'b1;
                m_ack_err = 1'($urandom);
                m_data_rd = 8'($urandom);
                len = $urandom_range(1, 4);
                repeat (len) begin
                    @(negedge clk);
                    checkOutput("wait_m_en", 32'(m_en), 32'd0);
                    checkOutput("wait_done", 32'(done), 32'd0);
                    checkOutput("wait_gnt", 32'(gnt), 32'(1) << w);
                end
                m_busy    = 1'b0;
                m_ack_err = ack_v;
                m_data_rd = data_v;
                @(negedge clk);
            end
            exp_err  = ack_v;
            exp_tmo  = 1'b0;
            exp_data = f_rw[w] ? 8'h00 : data_v;
        end
        checkOutput("done_pulse", 32'(done), 32'(1) << w);
        checkOutput("done_gnt", 32'(gnt), 32'(1) << w);
        checkOutput("done_m_en", 32'(m_en), 32'd0);
        checkOutput("rsp_data", 32'(rsp_data), 32'(exp_data));
        checkOutput("rsp_err", 32'(rsp_err), 32'(exp_err));
        checkOutput("rsp_tmo", 32'(rsp_tmo), 32'(exp_tmo));
        checkFields("done", w);
        m_ack_err = 1'($urandom);
        m_data_rd = 8'($urandom);
        req = '0;
        @(negedge clk);
        checkOutput("idle_gnt", 32'(gnt), 32'd0);
        checkOutput("idle_done", 32'(done), 32'd0);
        checkOutput("idle_arb_busy", 32'(arb_busy), 32'd0);
        checkOutput("idle_rsp_data", 32'(rsp_data), 32'(exp_data));
        checkFields("idle", w);
        model_ptr = (w + 1) % NREQ;
    endtask

    // Keeps the run bounded even if the DUT wedges somewhere unexpected.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [NREQ-1:0] rv;
        int w;
        rst = 1'b1;
        req = '0;
        req_addr = '0;
        req_rw = '0;
        req_mem_addr = '0;
        req_data_wr = '0;
        m_busy = 1'b0;
        m_ack_err = 1'b0;
        m_data_rd = 8'h00;
        repeat (2) @(negedge clk);
        checkOutput("rst_m_en", 32'(m_en), 32'd0);
        checkOutput("rst_gnt", 32'(gnt), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_arb_busy", 32'(arb_busy), 32'd0);
        checkOutput("rst_rsp", 32'({rsp_data, rsp_err, rsp_tmo}), 32'd0);
        checkOutput("rst_m_fields", 32'({m_addr, m_rw, m_mem_addr, m_data_wr}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] round-robin with all requests held");
        for (int k = 0; k < 5; k++) begin
            randomizeFields();
            ack_v = 1'b0;
            applyStimulus(4'b1111, 1'b0, 0, 1'b0);
        end

        $display("[TB] single read");
        randomizeFields();
        f_addr[1] = 7'h50;
        f_mem[1]  = 5'h03;
        f_rw[1]   = 1'b0;
        ack_v     = 1'b0;
        data_v    = 8'hA5;
        applyStimulus(4'b0010, 1'b0, 0, 1'b0);

        $display("[TB] NACK write");
        randomizeFields();
        f_rw[2]   = 1'b1;
        f_data[2] = 8'h3C;
        ack_v     = 1'b1;
        applyStimulus(4'b0100, 1'b0, 0, 1'b1);

        $display("[TB] launch timeout");
        randomizeFields();
        applyStimulus(4'b0001, 1'b1, 0, 1'b0);

        $display("[TB] foreign busy");
        randomizeFields();
        ack_v = 1'b0;
        applyStimulus(4'b0001, 1'b0, 3, 1'b0);

        $display("[TB] random transactions");
        for (int k = 0; k < 60; k++) begin
            randomizeFields();
            rv = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            applyStimulus(rv, $urandom_range(0, 7) == 0,
                          ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                          1'($urandom));
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                checkOutput("gap_arb_busy", 32'(arb_busy), 32'd0);
            end
        end

        $display("[TB] reset during WAIT");
        randomizeFields();
        driveFields();
        rv = 4'b0100;
        req = rv;
        w = pickWinner(rv);
        @(negedge clk);
        checkOutput("rw_launch_gnt", 32'(gnt), 32'(1) << w);
        m_busy = 1'b1;
        @(negedge clk);
        checkOutput("rw_wait_m_en", 32'(m_en), 32'd0);
        #2 rst = 1'b1;
        #1;
        checkOutput("rw_rst_gnt", 32'(gnt), 32'd0);
        checkOutput("rw_rst_m_en", 32'(m_en), 32'd0);
        checkOutput("rw_rst_arb_busy", 32'(arb_busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_ptr = 0;
        exp_data  = 8'h00;
        repeat (3) begin
            @(negedge clk);
            checkOutput("rw_hold_m_en", 32'(m_en), 32'd0);
            checkOutput("rw_hold_gnt", 32'(gnt), 32'd0);
        end
        m_busy = 1'b0;
        w = pickWinner(rv);
        @(negedge clk);
        checkOutput("rw_relaunch_m_en", 32'(m_en), 32'd1);
        checkOutput("rw_relaunch_gnt", 32'(gnt), 32'(1) << w);
        checkFields("rw_relaunch", w);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/i2c_arbiter.md
Name: i2c_arbiter

Overview:
Round-robin arbiter and sequencer that shares one i2c_master between NREQ requesters. It latches the winning request, drives the master's en/addr/rw/mem_addr/data_wr, and tracks the master's busy handshake to completion. It then returns read data and ACK status to the winner with a one-cycle done pulse. It sits between bus-client logic (config loaders, sensor pollers) and the single i2c_master instance.

Parameters:
NREQ, 4, number of requesters (2..8)
TMO_W, 8, width of launch-timeout counter; timeout fires at 2**TMO_W-1 cycles
MAX_RETRY, 2, NACK retries per transaction (used only with I2C_ARB_RETRY_EN)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  asynchronous, active-high reset
req  in  NREQ  per-requester transaction request, level
req_addr  in  7*NREQ  packed 7-bit slave addresses; requester i at [7i+6:7i]
req_rw  in  NREQ  1=write, 0=read
req_mem_addr  in  5*NREQ  packed 5-bit register addresses
req_data_wr  in  8*NREQ  packed write bytes
gnt  out  NREQ  one-hot; winner's bit high from accept until done cycle inclusive
done  out  NREQ  one-cycle completion pulse to winner
rsp_data  out  8  read byte of last completed transaction
rsp_err  out  1  last transaction ended in NACK or timeout
rsp_tmo  out  1  last transaction ended in launch timeout
arb_busy  out  1  high whenever state != IDLE
m_en  out  1  to i2c_master en
m_addr  out  7  to i2c_master addr
m_rw  out  1  to i2c_master rw
m_mem_addr  out  5  to i2c_master mem_addr
m_data_wr  out  8  to i2c_master data_wr
m_busy  in  1  from i2c_master busy
m_ack_err  in  1  from i2c_master ack_err
m_data_rd  in  8  from i2c_master data_rd

Behaviour:
- Reset: every output 0; state IDLE; round-robin pointer ptr=0; timeout counter 0.
- States: IDLE, LAUNCH, WAIT, DONE. All outputs registered.
- IDLE: if |req and m_busy==0, pick the first set req bit searching ptr, ptr+1, ... (mod NREQ).
  - Latch the winner's fields into m_addr/m_rw/m_mem_addr/m_data_wr.
  - Set gnt[w]=1 and m_en=1, then go LAUNCH.
  - Latency: req sampled high at edge N gives m_en high after edge N.
  - If m_busy==1 in IDLE (foreign user), stay in IDLE and launch nothing.
- LAUNCH: hold m_en=1 until m_busy sampled 1, then m_en=0 and go WAIT; clear the counter.
  - The counter increments every LAUNCH cycle.
  - At 2**TMO_W-1 without busy: m_en=0, rsp_err=1, rsp_tmo=1, rsp_data unchanged, go DONE.
- WAIT: on the first cycle m_busy sampled 0:
  - rsp_err=m_ack_err and rsp_tmo=0.
  - rsp_data=m_data_rd if m_rw==0, else 8'h00.
  - Go DONE.
- DONE: done[w]=1 for exactly this cycle, with gnt[w] still 1.
  - Next cycle: gnt=0, ptr=(w+1) mod NREQ, state IDLE. A new accept is earliest the cycle after DONE.
- m_* fields stay stable from accept through DONE; they hold their last value in IDLE.
- rsp_data/rsp_err/rsp_tmo are valid in the DONE cycle and held until the next DONE.
- req dropping while granted is ignored; the transaction completes and done still pulses.
- A req still high at done re-competes at the lowest priority because ptr has advanced.
- No starvation: any held req is served within NREQ transactions.
- Async rst mid-transaction: m_en and gnt drop immediately. The master is not aborted; after reset, IDLE waits for m_busy==0 before launching.

Optional Feature:
I2C_ARB_RETRY_EN
- Defined: in WAIT, if completion has m_ack_err==1 and attempt count < MAX_RETRY, increment the count and return to LAUNCH with m_en=1 next cycle.
  - gnt is held and done is not pulsed during retries.
  - rsp_err=1 only if the final attempt NACKs.
  - Attempt count clears on accept; the timeout path never retries.
- Undefined: single attempt; NACK goes straight to DONE with rsp_err=1.

Test Plan:
- Single read: req[1]=1, addr 7'h50, mem 5'h03, rw=0; model returns 8'hA5 with ACK -> m_en one cycle after req, gnt=4'b0010, done[1] pulse, rsp_data=8'hA5, rsp_err=0.
- Round-robin: req=4'b1111 held through 4 transactions from reset -> grant order 0,1,2,3, then 0 again; never two gnt bits high.
- NACK write: req[2], rw=1, data 8'h3C; model ack_err=1 -> rsp_err=1, rsp_data=8'h00. With I2C_ARB_RETRY_EN, exactly 3 m_en launches before done.
- Timeout: model never raises busy, TMO_W=4 -> m_en high 15 cycles, then done with rsp_err=1, rsp_tmo=1.
- Foreign busy: m_busy=1 in IDLE with req[0]=1 -> no m_en until busy low, then launch next cycle.
- Reset mid-WAIT: assert rst -> gnt=0, m_en=0, arb_busy=0 immediately; after release with m_busy still 1, no launch until it falls.
